// File: rtl/shift_rotate_engine_pkg.sv
// Shared definitions for the shift/rotate engine.
// Holds the MODE encodings, the FSM state codes and small mode-decoding
// helpers used by the top level and by the step unit.
package shift_rotate_engine_pkg;

    localparam logic [2:0] MODE_LOAD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SAR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // True for the five modes that move bits (SHL..ROR).
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ROR);
    endfunction

    function automatic logic is_left_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

    function automatic logic is_rotate_mode(input logic [2:0] m);
        return (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_rotate_engine_step.sv
// shift_step_unit: combinational shift/rotate of a W-bit word by k positions
// (0..STEP) in one direction.
// Ports:
//   mode  in   3   operation (SHL/SHR/SAR/ROL/ROR; anything else passes through)
//   k     in   KW  positions to move this step, 0..STEP
//   din   in   W   current word
//   fill  in   1   bit entering the vacated end for SHL/SHR
//   dout  out  W   shifted/rotated word
//   so    out  1   last bit leaving the word on this step (0 when k=0)
module shift_step_unit
    import shift_rotate_engine_pkg::*;
#(
    parameter int W    = 32,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [2:0]    mode,
    input  logic [KW-1:0] k,
    input  logic [W-1:0]  din,
    input  logic          fill,
    output logic [W-1:0]  dout,
    output logic          so
);

    // ext supplies the bits that flow into the vacated end: the fill bit,
    // the replicated MSB (SAR) or the word itself (rotates).
    logic [W-1:0]   ext;
    logic [2*W-1:0] wide;
    logic [2*W-1:0] wide_so;
    logic [KW-1:0]  k_m1;

    always_comb begin
        ext     = {W{fill}};
        wide    = '0;
        wide_so = '0;
        dout    = din;
        so      = 1'b0;
        k_m1    = k - KW'(1);
        if (is_rotate_mode(mode)) begin
            ext = din;
        end else if (mode == MODE_SAR) begin
            ext = {W{din[W-1]}};
        end

        if (is_shift_mode(mode)) begin
            if (is_left_mode(mode)) begin
                wide    = {din, ext} << k;
                wide_so = {din, ext} << k_m1;
                dout    = wide[2*W-1:W];
                so      = (k != '0) ? wide_so[2*W-1] : 1'b0;
            end else begin
                wide    = {ext, din} >> k;
                wide_so = {ext, din} >> k_m1;
                dout    = wide[W-1:0];
                so      = (k != '0) ? wide_so[0] : 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_rotate_engine.sv
// shift_rotate_engine: multi-cycle universal shift/rotate register moving
// STEP bit positions per clock.
// Ports:
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous reset, active-low
//   start      in   1   operation request, sampled only while busy=0
//   mode       in   3   LOAD/SHL/SHR/SAR/ROL/ROR, 110/111 are NOPs
//   amt        in   AW  shift amount, values above W clamp to W
//   d          in   W   parallel load data
//   sl, sr     in   1   serial fill for SHL / SHR
//   q          out  W   register contents
//   so         out  1   last bit shifted/rotated out
//   busy       out  1   shift in progress
//   done       out  1   one-cycle completion pulse
//   dbg_state  out  1   FSM state (ST_IDLE/ST_SHIFT)
//
// Handshake: start is taken on any edge where busy=0 (including the cycle
// done is high); mode, clamped amt, sl and sr are captured there and later
// input changes are ignored. busy stays high until the edge performing the
// final step, after which done is high for exactly one cycle. start while
// busy=1 is dropped, never queued.
module shift_rotate_engine
    import shift_rotate_engine_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int STEP = 1,
    localparam int AW   = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [W-1:0]  d,
    input  logic          sl,
    input  logic          sr,
    output logic [W-1:0]  q,
    output logic          so,
    output logic          busy,
    output logic          done,
    output logic [0:0]    dbg_state
);

    localparam int KW = $clog2(STEP + 1);

    logic [0:0]    state;
    logic [AW-1:0] rem;
    logic [2:0]    lmode;
    logic          lsl;
    logic          lsr;

    logic [AW-1:0] amt_c;
    logic [KW-1:0] k_step;
    logic          last_step;
    logic          fill;
    logic [W-1:0]  step_q;
    logic          step_so;

    assign amt_c     = (amt > AW'(W)) ? AW'(W) : amt;
    // The final step may be shorter than STEP when n is not a multiple of it.
    assign last_step = (rem <= AW'(STEP));
    assign k_step    = last_step ? KW'(rem) : KW'(STEP);
    assign fill      = (lmode == MODE_SHR) ? lsr : lsl;

    shift_step_unit #(
        .W    (W),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .mode (lmode),
        .k    (k_step),
        .din  (q),
        .fill (fill),
        .dout (step_q),
        .so   (step_so)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            lmode <= MODE_LOAD;
            lsl   <= 1'b0;
            lsr   <= 1'b0;
            q     <= '0;
            so    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lmode <= mode;
                        rem   <= amt_c;
                        lsl   <= sl;
                        lsr   <= sr;
                        if (mode == MODE_LOAD) begin
                            q    <= d;
                            done <= 1'b1;
                        end else if (is_shift_mode(mode) && (amt_c != '0)) begin
                            state <= ST_SHIFT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q   <= step_q;
                    rem <= rem - AW'(k_step);
                    // Only the final step's exiting bit is architecturally visible.
                    if (last_step) begin
                        so    <= step_so;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_SHIFT);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Bench for shift_rotate_engine: two instances (STEP=1 and STEP=4) driven in
// lockstep, table-driven vectors plus random ops checked against a
// closed-form model, and hand sequences for reset and ignored starts.
module tb_shift_rotate_engine;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [5:0]  amt = 6'd0;
    logic [31:0] d = 32'd0;
    logic        sl = 1'b0;
    logic        sr = 1'b0;

    logic [31:0] q0, q1;
    logic        so0, so1, busy0, busy1, done0, done1;
    logic [0:0]  st0, st1;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    logic [31:0] m_q = 32'd0;
    logic        m_so = 1'b0;

    always #5 clk = ~clk;

    shift_rotate_engine #(.W(W), .STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .d(d),
        .sl(sl), .sr(sr), .q(q0), .so(so0), .busy(busy0), .done(done0),
        .dbg_state(st0)
    );

    shift_rotate_engine #(.W(W), .STEP(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .d(d),
        .sl(sl), .sr(sr), .q(q1), .so(so1), .busy(busy1), .done(done1),
        .dbg_state(st1)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [5:0]  amt;
        logic [31:0] init;
        logic        sl;
        logic        sr;
        logic        keep_so;
        logic [31:0] exp_q;
        logic        exp_so;
        int          poke;
    } vec_t;

    vec_t tbl[11];

    function automatic int cyc(input logic [2:0] m, input logic [5:0] a, input int step);
        int n;
        n = (a > 6'd32) ? 32 : int'(a);
        if (m >= 3'd1 && m <= 3'd5 && n > 0) return (n + step - 1) / step;
        return 0;
    endfunction

    // Whole-operation reference: result of n positions in one go.
    function automatic logic [32:0] model(input logic [2:0] m, input logic [5:0] a,
                                          input logic [31:0] dd, input logic s_l,
                                          input logic s_r, input logic [31:0] cq,
                                          input logic cso);
        int          n;
        logic [63:0] t;
        logic [31:0] r;
        logic        o;
        n = (a > 6'd32) ? 32 : int'(a);
        r = cq;
        o = cso;
        if (m == 3'd0) begin
            r = dd;
        end else if (m <= 3'd5 && n > 0) begin
            case (m)
                3'd1: begin t = {cq, {32{s_l}}} << n;   r = t[63:32]; o = cq[32-n]; end
                3'd2: begin t = {{32{s_r}}, cq} >> n;   r = t[31:0];  o = cq[n-1];  end
                3'd3: begin t = {{32{cq[31]}}, cq} >> n; r = t[31:0]; o = cq[n-1];  end
                3'd4: begin t = {cq, cq} << n;          r = t[63:32]; o = cq[32-n]; end
                default: begin t = {cq, cq} >> n;       r = t[31:0];  o = cq[n-1];  end
            endcase
        end
        return {o, r};
    endfunction

    // Scoreboard: pop and compare whenever a DUT signals done.
    task automatic sb_check();
        logic [32:0] e;
        if (done0) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_unexpected_done got q=%h so=%b want no done", q0, so0);
            end else begin
                e = exp_q0.pop_front();
                if ({so0, q0} !== e) begin
                    errors++;
                    $display("FAIL sb0_result got so=%b q=%h want so=%b q=%h", so0, q0, e[32], e[31:0]);
                end
            end
        end
        if (done1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_done got q=%h so=%b want no done", q1, so1);
            end else begin
                e = exp_q1.pop_front();
                if ({so1, q1} !== e) begin
                    errors++;
                    $display("FAIL sb1_result got so=%b q=%h want so=%b q=%h", so1, q1, e[32], e[31:0]);
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Issue one operation to both DUTs and wait for both done pulses.
    // poke >= 0 fires a stray SHL start at that cycle while busy.
    task automatic do_op(input logic [2:0] m, input logic [5:0] a, input logic [31:0] dd,
                         input logic s_l, input logic s_r, input logic [32:0] e, input int poke);
        int c0, c1;
        bit d0, d1;
        exp_q0.push_back(e);
        exp_q1.push_back(e);
        @(negedge clk);
        mode = m; amt = a; d = dd; sl = s_l; sr = s_r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs: the captured values must be used.
        mode = 3'($urandom_range(0, 7));
        amt  = 6'($urandom_range(0, 63));
        d    = $urandom();
        sl   = ~s_l;
        sr   = ~s_r;
        c0 = 0; c1 = 0; d0 = 0; d1 = 0;
        for (int t = 0; t < 100 && !(d0 && d1); t++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy1) c1++;
            if (done0) d0 = 1;
            if (done1) d1 = 1;
            sb_check();
            if (t == poke) begin
                start = 1'b1; mode = 3'd1; amt = 6'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (!(d0 && d1)) begin
            errors++;
            $display("FAIL done_timeout got d0=%b d1=%b want 1 1", d0, d1);
        end
        check_val("busy_cycles_step1", 64'(c0), 64'(cyc(m, a, 1)));
        check_val("busy_cycles_step4", 64'(c1), 64'(cyc(m, a, 4)));
        @(negedge clk);
        check_val("done_single_pulse", {62'd0, done0, done1}, 64'd0);
        sb_check();
        m_q  = e[31:0];
        m_so = e[32];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] e;
        logic [2:0]  rm;
        logic [5:0]  ra;
        logic [31:0] rd;
        logic        rsl, rsr;

        //            mode  amt    init          sl    sr    keep  exp_q         so    poke
        tbl[0]  = '{3'd1, 6'd4,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF0, 1'b1, -1};
        tbl[1]  = '{3'd3, 6'd8,  32'h80000001, 1'b0, 1'b0, 1'b0, 32'hFF800000, 1'b0, -1};
        tbl[2]  = '{3'd5, 6'd40, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 5};
        tbl[3]  = '{3'd2, 6'd16, 32'h0000ABCD, 1'b0, 1'b1, 1'b0, 32'hFFFF0000, 1'b1, -1};
        tbl[4]  = '{3'd4, 6'd8,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h34567812, 1'b0, -1};
        tbl[5]  = '{3'd1, 6'd32, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, -1};
        tbl[6]  = '{3'd2, 6'd1,  32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, -1};
        tbl[7]  = '{3'd3, 6'd32, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, -1};
        tbl[8]  = '{3'd6, 6'd5,  32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, -1};
        tbl[9]  = '{3'd1, 6'd0,  32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, -1};
        tbl[10] = '{3'd5, 6'd4,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h81234567, 1'b1, -1};

        // Reset held with start=1: everything stays zero.
        rst = 1'b0; start = 1'b1; mode = 3'd1; amt = 6'd4; d = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("reset_dut0", {29'd0, q0, so0, busy0, done0}, 64'd0);
            check_val("reset_dut1", {29'd0, q1, so1, busy1, done1}, 64'd0);
        end
        start = 1'b0;
        rst = 1'b1;
        m_q = 32'd0; m_so = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(3'd0, 6'd0, tbl[i].init, 1'b0, 1'b0, {m_so, tbl[i].init}, -1);
            e = {tbl[i].keep_so ? m_so : tbl[i].exp_so, tbl[i].exp_q};
            do_op(tbl[i].mode, tbl[i].amt, 32'hDEADBEEF, tbl[i].sl, tbl[i].sr, e, tbl[i].poke);
        end

        // Random ops against the model, chained on the previous result.
        for (int i = 0; i < 12; i++) begin
            rm  = 3'($urandom_range(0, 7));
            ra  = 6'($urandom_range(0, 40));
            rd  = $urandom();
            rsl = 1'($urandom_range(0, 1));
            rsr = 1'($urandom_range(0, 1));
            e = model(rm, ra, rd, rsl, rsr, m_q, m_so);
            do_op(rm, ra, rd, rsl, rsr, e, -1);
        end

        // Reset in the middle of a SHR 16 aborts it.
        do_op(3'd0, 6'd0, 32'h0000FFFF, 1'b0, 1'b0, {m_so, 32'h0000FFFF}, -1);
        @(negedge clk);
        mode = 3'd2; amt = 6'd16; sr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_shift_busy", {62'd0, busy0, busy1}, 64'd3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_val("abort_dut0", {29'd0, q0, so0, busy0, done0}, 64'd0);
        check_val("abort_dut1", {29'd0, q1, so1, busy1, done1}, 64'd0);
        m_q = 32'd0; m_so = 1'b0;

        // Zero-amount shift after the abort: done only, q untouched.
        do_op(3'd1, 6'd0, 32'h0, 1'b1, 1'b1, {1'b0, 32'h0}, -1);

        check_val("sb0_drained", 64'(exp_q0.size()), 64'd0);
        check_val("sb1_drained", 64'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
